// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset vector, bus size codes
// and the fetch-buffer entry layout.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;
    localparam logic [1:0]  SIZE_WORD    = 2'b10;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        filled;
    } fq_entry_t;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// In-order fetch buffer: entries are allocated at request time,
// filled by responses in order, and popped from the head.
module if_fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alloc_i,
    input  logic [31:0]                alloc_pc_i,
    input  logic                       fill_i,
    input  logic [31:0]                fill_data_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    output logic                       head_valid_o,
    output logic [31:0]                head_pc_o,
    output logic [31:0]                head_inst_o,
    output logic [$clog2(DEPTH):0]     cnt_o,
    output logic [$clog2(DEPTH):0]     unfilled_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fq_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     tail_q, tail_d;
    logic [AW-1:0]     fptr_q, fptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     unf_q, unf_d;

    // Pointer and counter next state; clear drops every entry at once.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        fptr_d = fptr_q;
        cnt_d  = cnt_q;
        unf_d  = unf_q;
        if (clear_i) begin
            head_d = tail_q;
            fptr_d = tail_q;
            cnt_d  = '0;
            unf_d  = '0;
        end else begin
            if (alloc_i) begin
                tail_d = tail_q + AW'(1);
            end
            if (fill_i) begin
                fptr_d = fptr_q + AW'(1);
            end
            if (pop_i) begin
                head_d = head_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(alloc_i) - CW'(pop_i);
            unf_d = unf_q + CW'(alloc_i) - CW'(fill_i);
        end
    end

    // Pointer and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            fptr_q <= '0;
            cnt_q  <= '0;
            unf_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            fptr_q <= fptr_d;
            cnt_q  <= cnt_d;
            unf_q  <= unf_d;
        end
    end

    // Entry storage: allocate at tail, fill at oldest unfilled slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (!clear_i) begin
            if (alloc_i) begin
                mem_q[tail_q] <= '{pc: alloc_pc_i, inst: 32'h0, filled: 1'b0};
            end
            if (fill_i) begin
                mem_q[fptr_q].inst   <= fill_data_i;
                mem_q[fptr_q].filled <= 1'b1;
            end
        end
    end

    assign head_valid_o = (cnt_q != '0) && mem_q[head_q].filled;
    assign head_pc_o    = mem_q[head_q].pc;
    assign head_inst_o  = mem_q[head_q].inst;
    assign cnt_o        = cnt_q;
    assign unfilled_o   = unf_q;

endmodule

// File: rtl/if_prefetch_stage.sv
// Pipelined instruction fetch: issues reads, tracks orphaned
// responses after a redirect, and hands instructions to ID.
module if_prefetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [3:0]  inst_wstrb,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          run_q;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] unfilled;
    logic [CW:0]   used;
    logic          accept;
    logic          drop;
    logic          fill;
    logic          pop;

    // Slots in use count both buffered entries and orphaned responses.
    assign used     = {1'b0, cnt} + {1'b0, disc_q};
    assign inst_req = run_q & ~flush & (used < (CW+1)'(DEPTH));
    assign accept   = inst_req & inst_addr_ok;
    assign drop     = inst_data_ok & (disc_q != '0);
    assign fill     = inst_data_ok & (disc_q == '0);
    assign pop      = out_valid & out_ready & ~flush;

    assign inst_wr    = 1'b0;
    assign inst_size  = SIZE_WORD;
    assign inst_addr  = pc_q;
    assign inst_wstrb = 4'h0;
    assign inst_wdata = 32'h0;

    if_fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .alloc_i      (accept),
        .alloc_pc_i   (pc_q),
        .fill_i       (fill),
        .fill_data_i  (inst_rdata),
        .pop_i        (pop),
        .clear_i      (flush),
        .head_valid_o (out_valid),
        .head_pc_o    (out_pc),
        .head_inst_o  (out_inst),
        .cnt_o        (cnt),
        .unfilled_o   (unfilled)
    );

    // Fetch PC and orphan count; a redirect orphans every unfilled entry.
    always_comb begin
        pc_d   = pc_q;
        disc_d = disc_q;
        if (flush) begin
            pc_d   = flush_pc;
            disc_d = disc_q + unfilled - CW'(inst_data_ok);
        end else begin
            if (accept) begin
                pc_d = pc_next(pc_q);
            end
            if (drop) begin
                disc_d = disc_q - CW'(1);
            end
        end
    end

    // State registers; run_q holds off requests while in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q  <= 1'b0;
            pc_q   <= RESET_PC;
            disc_q <= '0;
        end else begin
            run_q  <= 1'b1;
            pc_q   <= pc_d;
            disc_q <= disc_d;
        end
    end

    a_no_spurious_rsp: assert property (
        @(posedge clk) disable iff (reset)
        inst_data_ok |-> ((disc_q != '0) || (unfilled != '0))
    );

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed and randomised bench for the prefetch stage,
// run on DEPTH=2, 4 and 8 instances side by side.
module tb_if_prefetch_stage;

    localparam logic [31:0] RPC = 32'h1c00_0000;

    typedef struct {
        logic [31:0] a;
        int          due;
    } pend_t;

    typedef struct {
        bit          req;
        logic [31:0] addr;
        bit          ov;
        logic [31:0] pc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic        req [3];
    logic        wr [3];
    logic [1:0]  size [3];
    logic [31:0] addr [3];
    logic [3:0]  wstrb [3];
    logic [31:0] wdata [3];
    logic        aok [3];
    logic        dok [3];
    logic [31:0] rdata [3];
    logic        ov [3];
    logic        rdy [3];
    logic [31:0] oinst [3];
    logic [31:0] opc [3];
    logic        fl [3];
    logic [31:0] fpc [3];

    int          lat [3];
    int          p_aok [3];
    int          p_dok [3];
    int          p_rdy [3];
    int          p_fl [3];
    bit          fl_req [3];
    logic [31:0] fl_tgt [3];
    int          nacc [3];
    int          ndel [3];
    logic [31:0] last_pc [3];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a5a_a5a5;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int D = 2 << g;
        pend_t       q[$];
        int          cyc;
        logic [31:0] exp_pc;
        bit          pf;
        logic [31:0] pf_pc;

        if_prefetch_stage #(
            .RESET_PC(RPC),
            .DEPTH(D)
        ) dut (
            .clk          (clk),
            .reset        (rst),
            .inst_req     (req[g]),
            .inst_wr      (wr[g]),
            .inst_size    (size[g]),
            .inst_addr    (addr[g]),
            .inst_wstrb   (wstrb[g]),
            .inst_wdata   (wdata[g]),
            .inst_addr_ok (aok[g]),
            .inst_data_ok (dok[g]),
            .inst_rdata   (rdata[g]),
            .out_valid    (ov[g]),
            .out_ready    (rdy[g]),
            .out_inst     (oinst[g]),
            .out_pc       (opc[g]),
            .flush        (fl[g]),
            .flush_pc     (fpc[g])
        );

        // Memory model, ID consumer and reference PC stream.
        initial begin
            aok[g] = 0; dok[g] = 0; rdata[g] = 0;
            rdy[g] = 0; fl[g] = 0; fpc[g] = 0;
            cyc = 0; exp_pc = RPC; pf = 0; pf_pc = 0;
            forever begin
                @(negedge clk);
                cyc++;
                if (rst) begin
                    q.delete();
                    exp_pc = RPC; pf = 0;
                    nacc[g] = 0; ndel[g] = 0;
                    aok[g] = 0; dok[g] = 0; rdata[g] = 0;
                    rdy[g] = 0; fl[g] = 0;
                end else begin
                    aok[g] = ($urandom_range(99) < p_aok[g]);
                    dok[g] = (q.size() != 0) && (q[0].due <= cyc)
                             && ($urandom_range(99) < p_dok[g]);
                    rdata[g] = dok[g] ? memf(q[0].a) : 32'h0;
                    rdy[g] = ($urandom_range(99) < p_rdy[g]);
                    if (fl_req[g]) begin
                        fl[g] = 1; fpc[g] = fl_tgt[g]; fl_req[g] = 0;
                    end else begin
                        fl[g] = ($urandom_range(99) < p_fl[g]);
                        fpc[g] = RPC + 32'h100 + ($urandom_range(15) << 4);
                    end
                    #1;
                    if (pf) begin
                        chk($sformatf("post_flush_ov[%0d]", g), ov[g], 0);
                        chk($sformatf("post_flush_addr[%0d]", g), addr[g], pf_pc);
                    end
                    pf = fl[g]; pf_pc = fpc[g];
                    if (fl[g]) chk($sformatf("flush_req[%0d]", g), req[g], 0);
                    if (req[g] && aok[g]) begin
                        q.push_back('{a: addr[g], due: cyc + lat[g]});
                        nacc[g]++;
                        chk($sformatf("outstanding[%0d]", g), q.size() <= D, 1);
                    end
                    if (dok[g]) void'(q.pop_front());
                    if (ov[g] && rdy[g] && !fl[g]) begin
                        chk($sformatf("pc[%0d]", g), opc[g], exp_pc);
                        chk($sformatf("inst[%0d]", g), oinst[g], memf(exp_pc));
                        last_pc[g] = opc[g];
                        ndel[g]++;
                        exp_pc = exp_pc + 4;
                    end
                    if (fl[g]) exp_pc = fpc[g];
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        step();
        rst = 1;
        step();
        step();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst_req[%0d]", g), req[g], 0);
            chk($sformatf("rst_ov[%0d]", g), ov[g], 0);
            chk($sformatf("rst_pc[%0d]", g), opc[g], 0);
            chk($sformatf("rst_inst[%0d]", g), oinst[g], 0);
            chk($sformatf("rst_addr[%0d]", g), addr[g], RPC);
        end
        rst = 0;
    endtask

    task automatic wait_del(input int n);
        for (int i = 0; i < 60 && ndel[1] < n; i++) step();
        chk("deliver_timeout", ndel[1] >= n, 1);
    endtask

    vec_t tv [6];
    int   n0;

    initial begin
        tv[0] = '{1'b1, 32'h1c00_0000, 1'b0, 32'h0};
        tv[1] = '{1'b1, 32'h1c00_0004, 1'b0, 32'h0};
        tv[2] = '{1'b1, 32'h1c00_0008, 1'b1, 32'h1c00_0000};
        tv[3] = '{1'b1, 32'h1c00_000c, 1'b1, 32'h1c00_0004};
        tv[4] = '{1'b1, 32'h1c00_0010, 1'b1, 32'h1c00_0008};
        tv[5] = '{1'b1, 32'h1c00_0014, 1'b1, 32'h1c00_000c};
        for (int g = 0; g < 3; g++) begin
            lat[g] = 1; p_aok[g] = 0; p_dok[g] = 0;
            p_rdy[g] = 0; p_fl[g] = 0; fl_req[g] = 0;
            fl_tgt[g] = 0; nacc[g] = 0; ndel[g] = 0; last_pc[g] = 0;
        end

        // single-cycle memory, consumer always ready
        lat[1] = 1; p_aok[1] = 100; p_dok[1] = 100; p_rdy[1] = 100;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("t1_req%0d", i), req[1], tv[i].req);
            chk($sformatf("t1_addr%0d", i), addr[1], tv[i].addr);
            chk($sformatf("t1_ov%0d", i), ov[1], tv[i].ov);
            if (tv[i].ov) chk($sformatf("t1_pc%0d", i), opc[1], tv[i].pc);
        end
        chk("const_wr", wr[1], 0);
        chk("const_size", size[1], 2'b10);
        chk("const_wstrb", wstrb[1], 0);
        chk("const_wdata", wdata[1], 0);

        // consumer stalled: buffer fills to DEPTH then requests stop
        p_rdy[1] = 0;
        do_reset();
        repeat (10) step();
        chk("full_acc", nacc[1], 4);
        chk("full_req", req[1], 0);
        chk("full_ov", ov[1], 1);
        chk("full_pc", opc[1], RPC);
        p_rdy[1] = 100;
        step();
        chk("pop_cycle_req", req[1], 0);
        step();
        chk("refill_req", req[1], 1);
        wait_del(4);

        // three-cycle memory latency
        lat[1] = 3;
        n0 = ndel[1];
        repeat (40) step();
        chk("lat3_thru", (ndel[1] - n0) >= 20, 1);

        // redirect with two requests in flight
        lat[1] = 5;
        do_reset();
        step();
        step();
        p_aok[1] = 0; fl_tgt[1] = 32'h1c00_0100; fl_req[1] = 1;
        step();
        chk("f4_acc", nacc[1], 2);
        chk("f4_req", req[1], 0);
        p_aok[1] = 100;
        wait_del(1);
        chk("f4_pc", last_pc[1], 32'h1c00_0100);

        // redirect coinciding with a response and a pop
        lat[1] = 2;
        do_reset();
        repeat (5) step();
        fl_tgt[1] = 32'h1c00_0200; fl_req[1] = 1;
        n0 = ndel[1];
        step();
        chk("f5_ov", ov[1], 1);
        chk("f5_dok", dok[1], 1);
        chk("f5_req", req[1], 0);
        wait_del(n0 + 1);
        chk("f5_pc", last_pc[1], 32'h1c00_0200);

        // random traffic on all three depths
        for (int g = 0; g < 3; g++) begin
            lat[g] = 1 + $urandom_range(3);
            p_aok[g] = 70; p_dok[g] = 70; p_rdy[g] = 70; p_fl[g] = 4;
        end
        do_reset();
        repeat (3000) step();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rand_progress[%0d]", g), ndel[g] >= 50, 1);
            p_fl[g] = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_prefetch_stage.md
# if_prefetch_stage

Parametrised instruction-fetch stage for the LoongArch pipeline; successor to the single-entry fixed-latency fetch stage. Issues pipelined reads on an SRAM-like request/response instruction port, tolerates variable memory latency, buffers up to DEPTH instructions in order, and presents them to ID through a valid/ready handshake. A redirect (`flush`) restarts fetch at a new PC and silently discards every in-flight response.

## Interface
Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset
- DEPTH, 4, buffer entries and outstanding-request bound; power of two, ≥2

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- inst_req  out  1  read request
- inst_wr  out  1  constant 0
- inst_size  out  2  constant 2'b10 (word)
- inst_addr  out  32  fetch address, equals fetch_pc
- inst_wstrb  out  4  constant 0
- inst_wdata  out  32  constant 0
- inst_addr_ok  in  1  request accepted this cycle when inst_req=1
- inst_data_ok  in  1  one response returned, in request order
- inst_rdata  in  32  response data, valid with inst_data_ok
- out_valid  out  1  head instruction available to ID
- out_ready  in  1  ID accepts head
- out_inst  out  32  head instruction
- out_pc  out  32  head PC
- flush  in  1  redirect
- flush_pc  in  32  redirect target, word aligned

## Operation
- State: fetch_pc; circular buffer of DEPTH entries {pc, inst, filled}; head/tail pointers; occupancy cnt (entries allocated); discard_cnt (orphaned in-flight responses).
- inst_req = ~flush & (cnt + discard_cnt < DEPTH). Registered-state terms only, plus combinational flush gating.
- Accept (inst_req & inst_addr_ok): allocate tail entry {pc=fetch_pc, filled=0}; fetch_pc += 4; tail++.
- Response (inst_data_ok): if discard_cnt≠0, discard_cnt−1 and data dropped; else write inst_rdata into oldest unfilled entry, set filled.
- out_valid = head entry allocated & filled. Pop on out_valid & out_ready: head++, cnt−1.
- Flush: all entries freed (cnt←0, head=tail), fetch_pc←flush_pc; discard_cnt ← discard_cnt + unfilled_cnt − (inst_data_ok ? 1 : 0). Pop in the same cycle is ignored. No request is accepted in the flush cycle.
- Pointer arithmetic: clog2(DEPTH)-bit, natural wrap; cnt and discard_cnt clog2(DEPTH)+1 bits, never exceeding DEPTH.
- inst_data_ok with no outstanding request is a protocol error; behaviour is undefined and flagged by an assertion.

## Timing
- Reset values: inst_req=0, out_valid=0, out_inst=0, out_pc=0 (head entry cleared), fetch_pc=RESET_PC, cnt=0, discard_cnt=0.
- First inst_req=1 with inst_addr=RESET_PC in the first cycle after reset deasserts.
- Accept at T, inst_data_ok at ≥T+1, out_valid at the cycle after inst_data_ok. Minimum fetch latency is 2 cycles from accept to out_valid.
- Sustained throughput of 1 instr/cycle requires DEPTH≥3 with single-cycle memory.
- Full: inst_req=0 while cnt+discard_cnt=DEPTH. A pop in the same cycle does not enable a request until the next cycle.
- After a flush at cycle F, inst_req rises at F+1 with inst_addr=flush_pc, if capacity allows. out_valid=0 at F+1.
- Reset mid-operation drops all state. Responses to pre-reset requests are not tracked; the memory is reset together with the stage.

## Structure
- Shared package `cpu_pkg`: RESET_PC default, SIZE_WORD=2'b10.
- Sub-module `if_fetch_fifo`: DEPTH-entry in-order buffer with alloc/fill/pop/clear and cnt/unfilled outputs. The top level holds fetch_pc, discard_cnt and request logic.

## Test plan
- Reset then single-cycle memory (addr_ok=1, data_ok next cycle), out_ready=1 → out_pc 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles starting at cycle 3 after reset deasserts.
- out_ready=0 for 10 cycles, DEPTH=4 → exactly 4 accepts (PCs 0x1c000000–0x1c00000c), inst_req then stays 0; releasing out_ready drains them in order with no loss.
- Memory latency 3, addr_ok always 1 → at most DEPTH outstanding; out_pc strictly +4, no gaps or duplicates.
- Two requests in flight, flush with flush_pc=0x1c000100 → both returning responses are dropped; first out_pc=0x1c000100 with its own data.
- Flush in the same cycle as inst_data_ok and an out pop → discard_cnt equals remaining in-flight count; popped instruction is not re-presented; next out_pc=flush_pc.
- DEPTH=2 and DEPTH=8 builds, random addr_ok/data_ok/out_ready/flush, compared against a reference PC stream → every delivered {pc, inst} matches memory at that pc and follows the last redirect.
